// File: rtl/nibble_packer.sv
// -----------------------------------------------------------------------------
// nibble_packer
//
// Packs a stream of 4-bit nibbles into 32-bit words, one slot at a time.
// Slot k of the word occupies bits [4k+3:4k]. Slot 0 is the first nibble of a
// word and sits at [3:0]. This is the write-side inverse of a 3-bit-select
// nibble read mux.
//
// A word ends on the eighth nibble, or earlier on a nibble tagged in_last.
// Slots that were never written hold PAD_NIB. The completed word is held on the
// output until the sink takes it, and no new nibble is accepted in that time.
//
// Parameters
//   PAD_NIB    nibble value placed in slots that were not written
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   source offers in_nib / in_last this cycle
//   in_ready   packer can take a nibble (FILL state)
//   in_nib     nibble data
//   in_last    offered nibble is the final one of the current word
//   out_valid  out_word / out_count hold a completed word (HOLD state)
//   out_ready  sink takes the word this cycle
//   out_word   packed word, slot k at bits [4k+3:4k]
//   out_count  number of nibbles written into out_word (1..8)
// -----------------------------------------------------------------------------
module nibble_packer #(
  parameter logic [3:0] PAD_NIB = 4'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_nib,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [3:0]  out_count
);

  typedef enum logic [0:0] {
    StFill,
    StHold
  } state_e;

  localparam logic [31:0] PadWord = {8{PAD_NIB}};

  state_e      state_q, state_d;
  logic [2:0]  ptr_q,   ptr_d;
  logic [31:0] word_q,  word_d;
  logic [3:0]  count_q, count_d;

  logic nib_xfer;
  logic word_end;

  // Handshake strobes. Both ready and valid come from state alone, so the
  // source side never sees a combinational path from out_ready.
  assign nib_xfer = (state_q == StFill) && in_valid;
  assign word_end = in_last || (ptr_q == 3'd7);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    word_d  = word_q;
    count_d = count_q;

    unique case (state_q)
      StFill: begin
        if (nib_xfer) begin
          // Unwritten slots already hold PAD_NIB: the word register is
          // cleared to the pad pattern on reset and on every drain, so only
          // the addressed slot changes here.
          word_d[{ptr_q, 2'b00} +: 4] = in_nib;
          ptr_d                       = ptr_q + 3'd1;
          if (word_end) begin
            state_d = StHold;
            count_d = {1'b0, ptr_q} + 4'd1;
          end
        end
      end

      StHold: begin
        // The pointer wrapped to 0 if the word ended at slot 7; it is forced
        // back to 0 here anyway so an early-last word restarts at slot 0.
        if (out_ready) begin
          state_d = StFill;
          ptr_d   = 3'd0;
          word_d  = PadWord;
          count_d = 4'd0;
        end
      end

      default: begin
        state_d = StFill;
        ptr_d   = 3'd0;
        word_d  = PadWord;
        count_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFill;
      ptr_q   <= 3'd0;
      word_q  <= PadWord;
      count_q <= 4'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      word_q  <= word_d;
      count_q <= count_d;
    end
  end

  assign in_ready  = (state_q == StFill);
  assign out_valid = (state_q == StHold);
  assign out_word  = word_q;
  assign out_count = count_q;

endmodule

// File: doc/nibble_packer.md
NIBBLE_PACKER -- requirements
Module: nibble_packer

Interface
REQ-001 Parameter: PAD_NIB, default 4'h0, nibble value placed in slots not written before a word is emitted.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  in_nib/in_last hold a nibble offered by the source.
REQ-005 in_ready  output  1  packer can accept a nibble this cycle.
REQ-006 in_nib  input  4  nibble data.
REQ-007 in_last  input  1  offered nibble is the final one of the current word; remaining slots get PAD_NIB.
REQ-008 out_valid  output  1  out_word/out_count hold a completed word.
REQ-009 out_ready  input  1  sink accepts the word this cycle.
REQ-010 out_word  output  32  packed word; slot k occupies bits [4k+3:4k], k=0..7.
REQ-011 out_count  output  4  number of nibbles written into out_word, 1..8.

Function
REQ-012 The packer SHALL be the write-side inverse of the register file's 3-bit-select nibble read mux: nibble n of a word SHALL land in bits [4n+3:4n], with slot 0 at [3:0] and slot 7 at [31:28].
REQ-013 The packer SHALL have exactly two states: FILL and HOLD.
REQ-014 In FILL: in_ready=1 and out_valid=0; in HOLD: in_ready=0 and out_valid=1.
- Both outputs are registered or decoded from state only.
- in_ready SHALL NOT depend combinationally on out_ready.
REQ-015 A nibble transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1.
- in_nib is written to slot ptr, where ptr is a 3-bit write pointer.
- ptr increments by 1.
REQ-016 When a transfer occurs with ptr=7, or with in_last=1, the packer SHALL enter HOLD on that edge.
- All slots above the written slot SHALL hold PAD_NIB.
- out_count SHALL equal the written slot index + 1.
REQ-017 ptr SHALL NOT wrap within a word: the transfer at ptr=7 always ends the word, regardless of in_last.
REQ-018 In FILL, out_word and out_count SHALL be held but are don't-care to the sink.
REQ-019 A word transfer SHALL occur on a rising edge in HOLD with out_ready=1. On that edge:
- state goes to FILL
- ptr goes to 0
- all eight slots go to PAD_NIB
- out_count goes to 0
REQ-020 While in HOLD with out_ready=0, out_word, out_count and out_valid SHALL remain stable until accepted.
REQ-021 in_valid and in_nib SHALL be ignored in HOLD; no slot changes and no nibble is lost, because in_ready=0.
REQ-022 out_ready SHALL be ignored in FILL.
REQ-023 Latency:
- The last nibble's transfer edge SHALL raise out_valid at that same edge, visible the following cycle.
- The minimum period for one full 8-nibble word SHALL be 9 cycles: 8 fills plus 1 drain.
REQ-024 A single-nibble word (in_last=1 at ptr=0) SHALL produce out_count=1, with PAD_NIB in slots 1..7.

Reset
REQ-025 When rst_n=0, regardless of clk, the packer SHALL immediately go to FILL and set:
- ptr=0, out_valid=0, in_ready=1
- out_word={8{PAD_NIB}}, out_count=0
REQ-026 Reset asserted mid-word or in HOLD SHALL discard the partial or pending word; no word is emitted for it after release.
REQ-027 The first transfer SHALL be accepted on the first rising edge at which rst_n=1 and in_valid=1.

Verification
REQ-028 Full word:
- Stimulus: nibbles 1,2,...,8 on consecutive cycles with in_last=0 and out_ready=1.
- Response: out_valid for exactly 1 cycle, out_word=32'h87654321, out_count=8, in_ready low for that cycle only.
REQ-029 Early last:
- Stimulus: nibbles A,B,C with in_last on C, PAD_NIB=0.
- Response: out_word=32'h00000CBA, out_count=3.
- Repeat with PAD_NIB=4'hF. Response: out_word=32'hFFFFFCBA.
REQ-030 Backpressure:
- Stimulus: complete word 32'hDEADBEEF, then hold out_ready=0 for 5 cycles while in_valid=1 with nibble 5.
- Response: out_word stays 32'hDEADBEEF, in_ready=0 throughout.
- Then: out_ready=1. Response: next word's slot 0 = 5.
REQ-031 Source gaps:
- Stimulus: in_valid toggling 1,0,1,0 over 16 cycles carrying 8 nibbles.
- Response: the same packed word as the gap-free case, with nibbles in order.
REQ-032 Reset mid-word:
- Stimulus: 4 nibbles written, then rst_n pulsed low for less than a clock period between edges.
- Response: out_valid=0 and out_word=PAD pattern immediately. The next 8 nibbles form a fresh word starting at slot 0.
REQ-033 Single-nibble word:
- Stimulus: in_nib=7 with in_last=1 at ptr=0.
- Response: out_word=32'h00000007, out_count=1.
- Then: back-to-back single-nibble words. Response: one word every 2 cycles.
